bram_share_ctl: RTL and testbench



---
 rtl/bram_share_ctl.sv | 145 ++++++++++++++
 tb/tb_bram_share_ctl.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_share_ctl.sv
// bram_share_ctl: shares one port of a 512x36 block RAM between two
// requesters. Clears every location to CLEAR_VAL after reset or on
// request, then grants single-word accesses round-robin and returns
// read data with a per-requester valid strobe.
module bram_share_ctl #(
    parameter int unsigned        ADDR_W    = 9,
    parameter int unsigned        DATA_W    = 36,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR_REQ,
    output logic              BUSY,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_W-1:0] BRAM_DIN,
    input  logic [DATA_W-1:0] BRAM_DOUT
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              gnt0, gnt1;

    // Round-robin grant; held off while in reset and in the cycle a clear is accepted
    always_comb begin
        logic run_ok;
        run_ok = RST_N && (state_q == ST_RUN) && !CLEAR_REQ;
        gnt0   = run_ok && REQ0 && (!REQ1 || !ptr_q);
        gnt1   = run_ok && REQ1 && (!REQ0 || ptr_q);
    end

    // RAM port drive: clear writes, granted access, or idle
    always_comb begin
        BRAM_EN   = 1'b0;
        BRAM_WE   = 1'b0;
        BRAM_ADDR = '0;
        BRAM_DIN  = '0;
        if (RST_N && (state_q == ST_CLEAR)) begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = 1'b1;
            BRAM_ADDR = cnt_q;
            BRAM_DIN  = CLEAR_VAL;
        end else if (gnt0) begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = WE0;
            BRAM_ADDR = ADDR0;
            BRAM_DIN  = WDATA0;
        end else if (gnt1) begin
            BRAM_EN   = 1'b1;
            BRAM_WE   = WE1;
            BRAM_ADDR = ADDR1;
            BRAM_DIN  = WDATA1;
        end
    end

    // Next-state logic for sequencer, clear counter, RR pointer and read strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        rvalid0_d = gnt0 && !WE0;
        rvalid1_d = gnt1 && !WE1;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (CLEAR_REQ) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else if (gnt0) begin
                    ptr_d = 1'b1;
                end else if (gnt1) begin
                    ptr_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                busy_d  = 1'b1;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            busy_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign GNT0    = gnt0;
    assign GNT1    = gnt1;
    assign BUSY    = busy_q;
    assign RVALID0 = rvalid0_q;
    assign RVALID1 = rvalid1_q;
    assign RDATA   = BRAM_DOUT;

endmodule

// File: tb/tb_bram_share_ctl.sv
// Testbench for bram_share_ctl: behavioural RAM plus a shadow-memory and
// round-robin reference model; inputs driven and outputs sampled on the
// falling clock edge.
module tb_bram_share_ctl;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 36;
    localparam int unsigned DEPTH = 512;
    localparam logic [DW-1:0] CV  = 36'h5_A5C33C5A;

    logic          CLK;
    logic          RST_N;
    logic          CLEAR_REQ;
    logic          BUSY;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          GNT0, GNT1, RVALID0, RVALID1;
    logic [DW-1:0] RDATA;
    logic          BRAM_EN, BRAM_WE;
    logic [AW-1:0] BRAM_ADDR;
    logic [DW-1:0] BRAM_DIN;
    logic [DW-1:0] BRAM_DOUT;

    bram_share_ctl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .CLEAR_VAL (CV)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .CLEAR_REQ (CLEAR_REQ),
        .BUSY      (BUSY),
        .REQ0      (REQ0),
        .REQ1      (REQ1),
        .WE0       (WE0),
        .WE1       (WE1),
        .ADDR0     (ADDR0),
        .ADDR1     (ADDR1),
        .WDATA0    (WDATA0),
        .WDATA1    (WDATA1),
        .GNT0      (GNT0),
        .GNT1      (GNT1),
        .RVALID0   (RVALID0),
        .RVALID1   (RVALID1),
        .RDATA     (RDATA),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_DIN  (BRAM_DIN),
        .BRAM_DOUT (BRAM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Block RAM port with registered read output
    logic [DW-1:0] bram_mem [DEPTH];
    always @(posedge CLK) begin
        if (BRAM_EN) begin
            if (BRAM_WE) bram_mem[BRAM_ADDR] <= BRAM_DIN;
            else         BRAM_DOUT <= bram_mem[BRAM_ADDR];
        end
    end

    // Reference model state
    logic [DW-1:0] shadow [DEPTH];
    bit            ptr_m;
    int            checks   = 0;
    int            failures = 0;

    task automatic test_reset(input int unsigned hold);
        int unsigned busy_n;
        int unsigned exp_a;
        RST_N = 1'b0; CLEAR_REQ = 1'b0;
        REQ0 = 1'b1; REQ1 = 1'b1; WE0 = 1'b0; WE1 = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            @(negedge CLK);
            checks++;
            if ({GNT0, GNT1, BRAM_EN, BRAM_WE, RVALID0, RVALID1, BUSY} !== 7'b0000001) begin
                failures++;
                $display("FAIL reset_outputs got gnt=%b%b en=%b we=%b rv=%b%b busy=%b want all 0, busy=1",
                         GNT0, GNT1, BRAM_EN, BRAM_WE, RVALID0, RVALID1, BUSY);
            end
        end
        RST_N = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
        busy_n = 0; exp_a = 0;
        for (int unsigned c = 0; c < 2000; c++) begin
            #1;
            if (!BUSY) break;
            busy_n++;
            if (BRAM_EN) begin
                checks++;
                if ({BRAM_WE, BRAM_ADDR, BRAM_DIN} !== {1'b1, exp_a[AW-1:0], CV}) begin
                    failures++;
                    $display("FAIL clear_write got we=%b addr=%0d din=%h want we=1 addr=%0d din=%h",
                             BRAM_WE, BRAM_ADDR, BRAM_DIN, exp_a, CV);
                end
                exp_a++;
            end
            @(negedge CLK);
        end
        checks++;
        if (busy_n !== 513) begin
            failures++;
            $display("FAIL reset_busy_cycles got %0d want 513", busy_n);
        end
        checks++;
        if (exp_a !== 512) begin
            failures++;
            $display("FAIL reset_clear_writes got %0d want 512", exp_a);
        end
        for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = CV;
        ptr_m = 1'b0;
    endtask

    task automatic test_readback_all();
        logic [DW-1:0] erd;
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                checks++;
                if ({RVALID0, RVALID1, RDATA} !== {2'b10, erd}) begin
                    failures++;
                    $display("FAIL readback addr=%0d got rv=%b%b data=%h want rv=10 data=%h",
                             i - 1, RVALID0, RVALID1, RDATA, erd);
                end
            end
            if (i < DEPTH) begin
                REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = AW'(i); REQ1 = 1'b0;
                #1;
                checks++;
                if ({GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR} !== {4'b1010, AW'(i)}) begin
                    failures++;
                    $display("FAIL readback_grant addr=%0d got gnt=%b%b en=%b we=%b baddr=%0d want gnt=10 en=1 we=0",
                             i, GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR);
                end
                erd = shadow[i];
                ptr_m = 1'b1;
            end else begin
                REQ0 = 1'b0;
            end
        end
    endtask

    task automatic test_single();
        localparam logic [DW-1:0] V = 36'h9_DEADBEEF;
        @(negedge CLK);
        REQ1 = 1'b0; REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd5; WDATA0 = V;
        #1;
        checks++;
        if ({GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN} !== {4'b1011, 9'd5, V}) begin
            failures++;
            $display("FAIL single_write got gnt=%b%b en=%b we=%b addr=%0d din=%h want 10/1/1/5/%h",
                     GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, V);
        end
        shadow[5] = V;
        @(negedge CLK);
        checks++;
        if ({RVALID0, RVALID1} !== 2'b00) begin
            failures++;
            $display("FAIL single_write_rvalid got %b%b want 00", RVALID0, RVALID1);
        end
        WE0 = 1'b0;
        #1;
        checks++;
        if ({GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR} !== {4'b1010, 9'd5}) begin
            failures++;
            $display("FAIL single_read_grant got gnt=%b%b en=%b we=%b addr=%0d want 10/1/0/5",
                     GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR);
        end
        @(negedge CLK);
        REQ0 = 1'b0;
        checks++;
        if ({RVALID0, RVALID1, RDATA} !== {2'b10, V}) begin
            failures++;
            $display("FAIL single_read_data got rv=%b%b data=%h want rv=10 data=%h", RVALID0, RVALID1, RDATA, V);
        end
        #1;
        checks++;
        if ({GNT0, GNT1, BRAM_EN, BRAM_WE} !== 4'b0000) begin
            failures++;
            $display("FAIL single_idle got gnt=%b%b en=%b we=%b want 0000", GNT0, GNT1, BRAM_EN, BRAM_WE);
        end
        @(negedge CLK);
        checks++;
        if ({RVALID0, RVALID1} !== 2'b00) begin
            failures++;
            $display("FAIL single_rvalid_pulse got %b%b want 00", RVALID0, RVALID1);
        end
        ptr_m = 1'b1;
    endtask

    task automatic test_contention();
        logic [DW-1:0] v0, v1, erd;
        logic [63:0]   r;
        bit            g, g_prev;
        r = {$urandom(), $urandom()}; v0 = r[DW-1:0];
        r = {$urandom(), $urandom()}; v1 = r[DW-1:0];
        @(negedge CLK);
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 9'd10; WDATA0 = v0; REQ1 = 1'b0;
        #1;
        checks++;
        if ({GNT0, GNT1} !== 2'b10) begin
            failures++;
            $display("FAIL contention_w0 got gnt=%b%b want 10", GNT0, GNT1);
        end
        shadow[10] = v0; ptr_m = 1'b1;
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b1; WE1 = 1'b1; ADDR1 = 9'd20; WDATA1 = v1;
        #1;
        checks++;
        if ({GNT0, GNT1} !== 2'b01) begin
            failures++;
            $display("FAIL contention_w1 got gnt=%b%b want 01", GNT0, GNT1);
        end
        shadow[20] = v1; ptr_m = 1'b0;
        g_prev = 1'b0;
        for (int unsigned k = 0; k <= 6; k++) begin
            @(negedge CLK);
            if (k > 0) begin
                checks++;
                if ({RVALID0, RVALID1, RDATA} !== {!g_prev, g_prev, erd}) begin
                    failures++;
                    $display("FAIL contention_rvalid k=%0d got rv=%b%b data=%h want rv=%b%b data=%h",
                             k, RVALID0, RVALID1, RDATA, !g_prev, g_prev, erd);
                end
            end
            if (k < 6) begin
                REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd10;
                REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'd20;
                #1;
                g = ptr_m;
                checks++;
                if ({GNT0, GNT1, BRAM_ADDR} !== {!g, g, (g ? 9'd20 : 9'd10)}) begin
                    failures++;
                    $display("FAIL contention_grant k=%0d got gnt=%b%b addr=%0d want gnt=%b%b",
                             k, GNT0, GNT1, BRAM_ADDR, !g, g);
                end
                erd = g ? shadow[20] : shadow[10];
                ptr_m = !g; g_prev = g;
            end else begin
                REQ0 = 1'b0; REQ1 = 1'b0;
            end
        end
    endtask

    task automatic test_boundary();
        logic [AW-1:0] oa [4];
        bit            ow [4];
        logic [DW-1:0] od [4];
        logic [DW-1:0] erd;
        logic [63:0]   r;
        bit            pend;
        oa[0] = 9'd0; oa[1] = 9'd511; oa[2] = 9'd0; oa[3] = 9'd511;
        ow[0] = 1'b1; ow[1] = 1'b1;   ow[2] = 1'b0; ow[3] = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            r = {$urandom(), $urandom()}; od[i] = r[DW-1:0];
        end
        pend = 1'b0;
        for (int unsigned k = 0; k <= 4; k++) begin
            @(negedge CLK);
            checks++;
            if ({RVALID0, RVALID1} !== {1'b0, pend} || (pend && RDATA !== erd)) begin
                failures++;
                $display("FAIL boundary_rvalid k=%0d got rv=%b%b data=%h want rv=0%b data=%h",
                         k, RVALID0, RVALID1, RDATA, pend, erd);
            end
            pend = 1'b0;
            REQ0 = 1'b0;
            if (k < 4) begin
                REQ1 = 1'b1; WE1 = ow[k]; ADDR1 = oa[k]; WDATA1 = od[k];
                #1;
                checks++;
                if ({GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR} !== {3'b011, ow[k], oa[k]}) begin
                    failures++;
                    $display("FAIL boundary_grant k=%0d got gnt=%b%b en=%b we=%b addr=%0d want 01/1/%b/%0d",
                             k, GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR, ow[k], oa[k]);
                end
                if (ow[k]) shadow[oa[k]] = od[k];
                else begin pend = 1'b1; erd = shadow[oa[k]]; end
                ptr_m = 1'b0;
            end else begin
                REQ1 = 1'b0;
            end
        end
    endtask

    task automatic test_random(input int unsigned n);
        bit            p0, p1, w0, w1, erv0, erv1, w;
        logic [AW-1:0] a0, a1, a;
        logic [DW-1:0] d0, d1, d, erd;
        logic [63:0]   r;
        int            g;
        p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        erv0 = 0; erv1 = 0; erd = '0;
        for (int unsigned k = 0; k <= n; k++) begin
            @(negedge CLK);
            checks++;
            if ({RVALID0, RVALID1} !== {erv0, erv1} || ((erv0 || erv1) && RDATA !== erd)) begin
                failures++;
                $display("FAIL random_rvalid k=%0d got rv=%b%b data=%h want rv=%b%b data=%h",
                         k, RVALID0, RVALID1, RDATA, erv0, erv1, erd);
            end
            erv0 = 0; erv1 = 0;
            if (k == n) begin
                p0 = 0; p1 = 0;
            end else begin
                if (!p0 && $urandom_range(0, 3) != 0) begin
                    p0 = 1; w0 = 1'($urandom_range(0, 1));
                    a0 = ($urandom_range(0, 7) == 0) ? AW'(511) : AW'($urandom_range(0, 15));
                    r = {$urandom(), $urandom()}; d0 = r[DW-1:0];
                end
                if (!p1 && $urandom_range(0, 3) != 0) begin
                    p1 = 1; w1 = 1'($urandom_range(0, 1));
                    a1 = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(0, 15));
                    r = {$urandom(), $urandom()}; d1 = r[DW-1:0];
                end
            end
            REQ0 = p0; WE0 = w0; ADDR0 = a0; WDATA0 = d0;
            REQ1 = p1; WE1 = w1; ADDR1 = a1; WDATA1 = d1;
            #1;
            g = -1;
            if (p0 && p1) g = int'(ptr_m);
            else if (p0)  g = 0;
            else if (p1)  g = 1;
            checks++;
            if ({GNT0, GNT1, BRAM_EN} !== {g == 0, g == 1, g >= 0}) begin
                failures++;
                $display("FAIL random_grant k=%0d got gnt=%b%b en=%b want gnt=%b%b en=%b",
                         k, GNT0, GNT1, BRAM_EN, g == 0, g == 1, g >= 0);
            end
            if (g >= 0) begin
                w = (g == 0) ? w0 : w1;
                a = (g == 0) ? a0 : a1;
                d = (g == 0) ? d0 : d1;
                checks++;
                if ({BRAM_WE, BRAM_ADDR} !== {w, a} || (w && BRAM_DIN !== d)) begin
                    failures++;
                    $display("FAIL random_access k=%0d got we=%b addr=%0d din=%h want we=%b addr=%0d din=%h",
                             k, BRAM_WE, BRAM_ADDR, BRAM_DIN, w, a, d);
                end
                if (w) shadow[a] = d;
                else begin erv0 = (g == 0); erv1 = (g == 1); erd = shadow[a]; end
                ptr_m = (g == 0);
                if (g == 0) p0 = 0; else p1 = 0;
            end else begin
                checks++;
                if (BRAM_WE !== 1'b0) begin
                    failures++;
                    $display("FAIL random_idle_we k=%0d got %b want 0", k, BRAM_WE);
                end
            end
        end
    endtask

    task automatic test_clear_mid();
        logic [DW-1:0] erd;
        int unsigned   busy_n;
        int unsigned   exp_a;
        @(negedge CLK);
        REQ1 = 1'b0; REQ0 = 1'b1; WE0 = 1'b0; ADDR0 = 9'd10;
        #1;
        checks++;
        if ({GNT0, GNT1} !== 2'b10) begin
            failures++;
            $display("FAIL clrmid_read_grant got gnt=%b%b want 10", GNT0, GNT1);
        end
        erd = shadow[10]; ptr_m = 1'b1;
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b1; WE1 = 1'b0; ADDR1 = 9'd20; CLEAR_REQ = 1'b1;
        checks++;
        if ({RVALID0, RVALID1, RDATA} !== {2'b10, erd}) begin
            failures++;
            $display("FAIL clrmid_inflight got rv=%b%b data=%h want rv=10 data=%h", RVALID0, RVALID1, RDATA, erd);
        end
        #1;
        checks++;
        if ({GNT0, GNT1, BRAM_EN} !== 3'b000) begin
            failures++;
            $display("FAIL clrmid_req_cycle got gnt=%b%b en=%b want 000", GNT0, GNT1, BRAM_EN);
        end
        busy_n = 0; exp_a = 0;
        for (int unsigned c = 0; c < 2000; c++) begin
            @(negedge CLK);
            CLEAR_REQ = 1'b0;
            #1;
            if (!BUSY) break;
            busy_n++;
            checks++;
            if ({GNT0, GNT1, RVALID0, RVALID1, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN} !==
                {6'b000011, exp_a[AW-1:0], CV}) begin
                failures++;
                $display("FAIL clrmid_clear c=%0d got gnt=%b%b rv=%b%b en=%b we=%b addr=%0d din=%h want addr=%0d",
                         c, GNT0, GNT1, RVALID0, RVALID1, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN, exp_a);
            end
            exp_a++;
        end
        checks++;
        if (busy_n !== 512) begin
            failures++;
            $display("FAIL clrmid_busy_cycles got %0d want 512", busy_n);
        end
        for (int unsigned i = 0; i < DEPTH; i++) shadow[i] = CV;
        checks++;
        if ({GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR} !== {4'b0110, 9'd20}) begin
            failures++;
            $display("FAIL clrmid_first_grant got gnt=%b%b en=%b we=%b addr=%0d want 01/1/0/20",
                     GNT0, GNT1, BRAM_EN, BRAM_WE, BRAM_ADDR);
        end
        ptr_m = 1'b0;
        @(negedge CLK);
        REQ1 = 1'b0;
        checks++;
        if ({RVALID0, RVALID1, RDATA} !== {2'b01, CV}) begin
            failures++;
            $display("FAIL clrmid_after_read got rv=%b%b data=%h want rv=01 data=%h", RVALID0, RVALID1, RDATA, CV);
        end
    endtask

    task automatic test_reset_mid_clear();
        int unsigned exp_a;
        bit          found;
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b0; CLEAR_REQ = 1'b1;
        exp_a = 0; found = 0;
        for (int unsigned c = 0; c < 1000; c++) begin
            @(negedge CLK);
            CLEAR_REQ = (exp_a == 100);
            #1;
            checks++;
            if ({BUSY, BRAM_EN, BRAM_WE, BRAM_ADDR} !== {3'b111, exp_a[AW-1:0]}) begin
                failures++;
                $display("FAIL rstmid_clear_seq got busy=%b en=%b we=%b addr=%0d want 1/1/1/%0d",
                         BUSY, BRAM_EN, BRAM_WE, BRAM_ADDR, exp_a);
            end
            if (exp_a == 200) begin found = 1; break; end
            exp_a++;
        end
        CLEAR_REQ = 1'b0;
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rstmid_reach_200 got last=%0d want 200", exp_a);
        end
        test_reset(2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t want completion", $time);
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; CLEAR_REQ = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0; WE0 = 1'b0; WE1 = 1'b0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        test_reset(3);
        test_readback_all();
        test_single();
        test_contention();
        test_boundary();
        test_random(400);
        test_clear_mid();
        test_readback_all();
        test_random(200);
        test_reset_mid_clear();
        test_readback_all();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
